// File: rtl/three_input_gate_arb_v.sv
// Round-robin arbiter/sequencer sharing one external three-input gate among N_REQ requesters.
// Grants one requester per IDLE->EVAL pass, drives the gate from registered operands, captures its result.
module three_input_gate_arb_v #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [3*N_REQ-1:0] i_abc,
   input  logic [2*N_REQ-1:0] i_code_vec,
   output logic [N_REQ-1:0]   o_gnt,
   output logic               o_gate_a,
   output logic               o_gate_b,
   output logic               o_gate_c,
   output logic [1:0]         o_gate_code,
   input  logic               i_gate_f,
   output logic               o_valid,
   output logic               o_f,
   output logic [ID_W-1:0]    o_id,
   output logic               o_busy
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   typedef enum logic {IDLE, EVAL} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             gate_a_q, gate_a_d;
   logic             gate_b_q, gate_b_d;
   logic             gate_c_q, gate_c_d;
   logic [1:0]       gate_code_q, gate_code_d;
   logic             valid_q, valid_d;
   logic             f_q, f_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             busy_q, busy_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;

   logic [N_REQ-1:0] win_oh;
   logic [IDX_W-1:0] win_idx;
   logic [2:0]       win_abc;
   logic [1:0]       win_code;
   int unsigned      scan;
   int unsigned      nxt;

   // Scan upward from the pointer with wrap; the first requester hit wins.
   always_comb begin
      win_oh   = '0;
      win_idx  = '0;
      win_abc  = '0;
      win_code = '0;
      scan     = 0;
      nxt      = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan = 32'(ptr_q) + i;
         if (scan >= N_REQ) begin
            scan = scan - N_REQ;
         end
         if ((win_oh == '0) && i_req[IDX_W'(scan)]) begin
            win_oh[IDX_W'(scan)] = 1'b1;
            win_idx              = IDX_W'(scan);
         end
      end
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (win_oh[k]) begin
            win_abc  = i_abc[3*k +: 3];
            win_code = i_code_vec[2*k +: 2];
         end
      end
      nxt = 32'(win_idx) + 1;
      if (nxt >= N_REQ) begin
         nxt = 0;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gate_a_d    = gate_a_q;
      gate_b_d    = gate_b_q;
      gate_c_d    = gate_c_q;
      gate_code_d = gate_code_q;
      valid_d     = 1'b0;
      f_d         = f_q;
      id_d        = id_q;
      busy_d      = busy_q;
      ptr_d       = ptr_q;
      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (i_req != '0) begin
               gnt_d       = win_oh;
               gate_a_d    = win_abc[2];
               gate_b_d    = win_abc[1];
               gate_c_d    = win_abc[0];
               gate_code_d = win_code;
               id_d        = ID_W'(win_idx);
               ptr_d       = ID_W'(nxt);
               busy_d      = 1'b1;
               state_d     = EVAL;
            end
         end
         EVAL: begin
            f_d     = i_gate_f;
            valid_d = 1'b1;
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gate_a_q    <= 1'b0;
         gate_b_q    <= 1'b0;
         gate_c_q    <= 1'b0;
         gate_code_q <= '0;
         valid_q     <= 1'b0;
         f_q         <= 1'b0;
         id_q        <= '0;
         busy_q      <= 1'b0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gate_a_q    <= gate_a_d;
         gate_b_q    <= gate_b_d;
         gate_c_q    <= gate_c_d;
         gate_code_q <= gate_code_d;
         valid_q     <= valid_d;
         f_q         <= f_d;
         id_q        <= id_d;
         busy_q      <= busy_d;
         ptr_q       <= ptr_d;
      end
   end

   assign o_gnt       = gnt_q;
   assign o_gate_a    = gate_a_q;
   assign o_gate_b    = gate_b_q;
   assign o_gate_c    = gate_c_q;
   assign o_gate_code = gate_code_q;
   assign o_valid     = valid_q;
   assign o_f         = f_q;
   assign o_id        = id_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_three_input_gate_arb_v.sv
// Bench for three_input_gate_arb_v: external gate model, cycle model of the arbiter, directed scenarios.
module tb_three_input_gate_arb_v;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [11:0]  abc;
   logic [7:0]   code_vec;
   logic [3:0]   gnt;
   logic         gate_a, gate_b, gate_c;
   logic [1:0]   gate_code;
   logic         gate_f;
   logic         valid;
   logic         f;
   logic [1:0]   id;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   three_input_gate_arb_v #(.N_REQ(4), .ID_W(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_abc(abc), .i_code_vec(code_vec),
      .o_gnt(gnt), .o_gate_a(gate_a), .o_gate_b(gate_b), .o_gate_c(gate_c),
      .o_gate_code(gate_code), .i_gate_f(gate_f), .o_valid(valid), .o_f(f),
      .o_id(id), .o_busy(busy)
   );

   function automatic logic gate_fn(input logic a, input logic b, input logic c, input logic [1:0] code);
      case (code)
         2'b00:   return a ^ b ^ c;
         2'b01:   return ~(a & b & c);
         2'b10:   return ~(a | b | c);
         default: return ~(a ^ b ^ c);
      endcase
   endfunction

   assign gate_f = gate_fn(gate_a, gate_b, gate_c, gate_code);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending operation flag, pointer as an integer, winner by smallest wrap distance.
   bit         m_on = 0;
   bit         m_pending;
   int         m_ptr;
   logic [3:0] m_gnt;
   logic       m_a, m_b, m_c, m_valid, m_f, m_busy;
   logic [1:0] m_code, m_id;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1; m_pending = 0; m_ptr = 0; m_gnt = '0;
         m_a = 0; m_b = 0; m_c = 0; m_code = '0; m_valid = 0; m_f = 0; m_id = '0; m_busy = 0;
      end else if (m_on) begin
         if (m_pending) begin
            m_f = gate_fn(m_a, m_b, m_c, m_code);
            m_valid = 1; m_gnt = '0; m_busy = 0; m_pending = 0;
         end else begin
            int best, bestd;
            best = -1; bestd = N;
            for (int k = 0; k < N; k++)
               if (req[k] && ((k - m_ptr + N) % N) < bestd) begin
                  bestd = (k - m_ptr + N) % N;
                  best  = k;
               end
            m_valid = 0;
            if (best >= 0) begin
               m_gnt = 4'(1 << best);
               m_a = abc[3*best+2]; m_b = abc[3*best+1]; m_c = abc[3*best];
               m_code = code_vec[2*best +: 2];
               m_id = 2'(best); m_ptr = (best + 1) % N;
               m_busy = 1; m_pending = 1;
            end else begin
               m_gnt = '0; m_busy = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("model_gnt",   32'(gnt),       32'(m_gnt));
         chk("model_ops",   {29'd0, gate_a, gate_b, gate_c}, {29'd0, m_a, m_b, m_c});
         chk("model_code",  32'(gate_code), 32'(m_code));
         chk("model_valid", 32'(valid),     32'(m_valid));
         chk("model_f",     32'(f),         32'(m_f));
         chk("model_id",    32'(id),        32'(m_id));
         chk("model_busy",  32'(busy),      32'(m_busy));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      // requester operands {a,b,c}: r3=011 r2=111 r1=101 r0=110; codes r3=10 r2=00 r1=01 r0=00
      abc      = {3'b011, 3'b111, 3'b101, 3'b110};
      code_vec = {2'b10, 2'b00, 2'b01, 2'b00};
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ops", {27'd0, gate_a, gate_b, gate_c, gate_code}, 0);
      rst = 1'b0;

      // single request from requester 0, XOR of 110
      req = 4'b0001;
      tick();
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_ops", {29'd0, gate_a, gate_b, gate_c}, 32'b110);
      chk("t1_code", 32'(gate_code), 0);
      chk("t1_busy", 32'(busy), 1);
      req = '0;
      tick();
      chk("t1_valid", 32'(valid), 1);
      chk("t1_f", 32'(f), 0);
      chk("t1_id", 32'(id), 0);
      tick();
      chk("t1_valid_pulse", 32'(valid), 0);

      // all four codes on requester 2 operands 111
      for (int i = 0; i < 4; i++) begin
         logic [3:0] exp_f;
         exp_f = 4'b0001;
         code_vec[5:4] = 2'(i);
         req = 4'b0100;
         tick();
         chk("t2_gnt", 32'(gnt), 32'h4);
         req = '0;
         tick();
         chk("t2_valid", 32'(valid), 1);
         chk("t2_f", 32'(f), 32'(exp_f[i]));
         chk("t2_id", 32'(id), 2);
      end
      code_vec[5:4] = 2'b00;
      tick();

      // all requesters held: strict rotation after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i % 2 == 0) begin
            chk("t3_gnt", 32'(gnt), 32'(1 << ((i / 2) % 4)));
            chk("t3_novalid", 32'(valid), 0);
         end else begin
            chk("t3_valid", 32'(valid), 1);
            chk("t3_id", 32'(id), 32'(((i - 1) / 2) % 4));
         end
      end

      // pointer wrap around the top
      req = 4'b1000;
      tick();
      chk("t4_gnt3", 32'(gnt), 32'h8);
      req = 4'b1001;
      tick();
      chk("t4_eval_nognt", 32'(gnt), 0);
      tick();
      chk("t4_gnt0", 32'(gnt), 32'h1);
      tick();
      tick();
      chk("t4_gnt3b", 32'(gnt), 32'h8);
      req = '0;
      tick();
      chk("t4_f", 32'(f), 0);
      tick();

      // reset during EVAL aborts the operation and clears the pointer
      req = 4'b0010;
      tick();
      chk("t5_gnt1", 32'(gnt), 32'h2);
      rst = 1'b1;
      req = '0;
      tick();
      chk("t5_valid", 32'(valid), 0);
      chk("t5_all", {24'd0, gnt, gate_a, gate_b, gate_c, f}, 0);
      chk("t5_id_busy", {29'd0, gate_code, busy}, 0);
      rst = 1'b0;
      req = 4'b0011;
      tick();
      chk("t5_gnt0", 32'(gnt), 32'h1);
      req = '0;
      tick();
      chk("t5_id", 32'(id), 0);
      tick();

      // request raised only during EVAL is served in the following IDLE cycle
      req = 4'b0010;
      tick();
      chk("t6_gnt1", 32'(gnt), 32'h2);
      req = 4'b0001;
      tick();
      chk("t6_no_gnt_eval", 32'(gnt), 0);
      chk("t6_valid1", 32'(valid), 1);
      chk("t6_f1", 32'(f), 1);
      chk("t6_id1", 32'(id), 1);
      tick();
      chk("t6_gnt0", 32'(gnt), 32'h1);
      req = '0;
      tick();
      chk("t6_valid0", 32'(valid), 1);
      chk("t6_f0", 32'(f), 0);
      chk("t6_id0", 32'(id), 0);
      tick();
      chk("t6_hold_ops", {29'd0, gate_a, gate_b, gate_c}, 32'b110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/three_input_gate_arb_v.md
Name: three_input_gate_arb_v

Overview:
- Round-robin arbiter and sequencer that shares one three_input_gate_v instance among N_REQ requesters.
- Each requester presents an operand triple (a, b, c) and a 2-bit function code.
- The block grants one requester at a time, drives the shared gate from registered operands, captures the gate result and returns it tagged with the requester ID.
- Sits between requester logic and the combinational gate; the gate itself is instantiated outside this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_req  input  N_REQ  per-requester request level
i_abc  input  3*N_REQ  operands; requester k uses bits [3k+2:3k] = {a,b,c}, a is MSB
i_code_vec  input  2*N_REQ  function code; requester k uses bits [2k+1:2k]
o_gnt  output  N_REQ  one-hot grant pulse, registered
o_gate_a  output  1  operand a to shared gate
o_gate_b  output  1  operand b to shared gate
o_gate_c  output  1  operand c to shared gate
o_gate_code  output  2  i_code to shared gate
i_gate_f  input  1  o_f returned from shared gate (combinational)
o_valid  output  1  result-valid pulse
o_f  output  1  captured gate result
o_id  output  ID_W  requester index that owns o_f
o_busy  output  1  high while in EVAL

Behaviour:
- Reset: when i_rst=1 at a clock edge:
  - state goes to IDLE.
  - o_gnt, o_gate_a/b/c, o_gate_code, o_valid, o_f, o_id and o_busy all go to 0.
  - The priority pointer goes to 0, so requester 0 has highest priority.
- Reset overrides everything. A reset during EVAL aborts the operation: no o_valid and no result for that grant.
- Function codes (gate contract): 00 = XOR3, 01 = NAND3, 10 = NOR3, 11 = XNOR3. The arbiter passes codes through unmodified and never decodes them.
- FSM has two states, IDLE and EVAL.
- IDLE:
  - If i_req == 0, stay in IDLE.
  - Otherwise select winner w: the first set bit of i_req searching upward from the pointer, with wrap-around modulo N_REQ.
  - At the edge: latch that requester's {a,b,c} into o_gate_a/b/c and its code into o_gate_code; o_gnt <= onehot(w); o_id <= w; pointer <= (w+1) mod N_REQ; go to EVAL.
- EVAL (exactly 1 cycle):
  - o_gnt is one-hot and o_busy=1.
  - Gate operands are stable for the whole cycle.
  - i_req is ignored; no arbitration happens in EVAL.
  - At the edge: o_f <= i_gate_f, o_valid <= 1, o_gnt <= 0, go to IDLE.
- Gate operand outputs hold their last value while in IDLE; they are not cleared after each operation.
- o_valid:
  - Single-cycle pulse in the cycle after EVAL.
  - Otherwise 0, including the cycle after a reset.
  - o_f and o_id hold their values until the next capture.
- Latency:
  - Request sampled in IDLE cycle t → o_gnt in cycle t+1 → o_valid/o_f in cycle t+2.
  - Maximum throughput is one operation per 2 cycles; the next grant may coincide with the o_valid cycle.
- Requester protocol:
  - Hold i_req and operands stable until o_gnt is seen.
  - Deassert i_req from the cycle after the grant, unless another operation is wanted.
  - i_req still high in the cycle after the grant counts as a new request.
- Fairness: with all requesters held continuously, grants rotate 0,1,…,N_REQ-1,0,… and no requester waits more than N_REQ grants.
- Simultaneous events:
  - A request arriving during EVAL is first considered in the following IDLE cycle.
  - The pointer only advances on a grant.
- Unused ID encodings (w >= N_REQ) are never produced.

Test Plan:
1. Reset then single request: i_req=0001, i_abc[2:0]=110, code=00 → o_gnt=0001 at t+1 with gate inputs a=1,b=1,c=0, code 00; at t+2 o_valid=1, o_f=0 (XOR), o_id=0.
2. All four codes on operands 111, requester 2 → o_f sequence 1 (XOR), 0 (NAND), 0 (NOR), 0 (XNOR), each with o_id=2 and one o_valid per operation.
3. i_req=1111 held for 8 operations after reset → grant order 0,1,2,3,0,1,2,3; o_valid every 2nd cycle.
4. Pointer wrap: grant 3, then i_req=1001 → next grant is 0; then i_req=1001 → grant 3.
5. Assert i_rst during EVAL (requester 1 granted) → no o_valid, all outputs 0 next cycle; next i_req=0011 → grant 0 (pointer reset).
6. Request from requester 0 raised only during an EVAL for requester 1 → not granted in EVAL; granted in the next IDLE cycle with o_valid 2 cycles later.
